// File: rtl/fnv1a_expand_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : fnv1a_expand_seq_if
// Brief    : Word write port (valid/ready) between the FNV-1a expander and
//            the exe_env word space.
// Revision : 1.0 - initial release
// ============================================================================
interface fnv1a_expand_seq_if #(
  parameter int ADDR_W = 8
);
  logic              wr_valid_o;
  logic              wr_ready_i;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [31:0]       wr_data_o;

  modport master (
    output wr_valid_o,
    output wr_addr_o,
    output wr_data_o,
    input  wr_ready_i
  );

  modport slave (
    input  wr_valid_o,
    input  wr_addr_o,
    input  wr_data_o,
    output wr_ready_i
  );
endinterface
`default_nettype wire

// File: rtl/fnv1a_expand_seq.sv
`default_nettype none
// ============================================================================
// Module   : fnv1a_expand_seq
// Brief    : Expands a 32-bit seed into LEN FNV-1a chain words written to
//            consecutive word addresses; returns the final chain value.
// Revision : 1.0 - initial release
// ============================================================================
module fnv1a_expand_seq #(
  parameter int          ADDR_W    = 8,
  parameter int          MAX_LEN   = 48,
  parameter int          LEN_W     = 6,
  parameter logic [31:0] FNV_PRIME = 32'h01000193
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              start_i,
  input  wire logic              cond_i,
  input  wire logic [31:0]       seed_i,
  input  wire logic [31:0]       salt_i,
  input  wire logic [ADDR_W-1:0] dest_i,
  input  wire logic [LEN_W-1:0]  len_i,
  fnv1a_expand_seq_if.master     wr,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [31:0]            hash_o
);

  localparam logic [LEN_W-1:0] c_MAX_LEN = LEN_W'(MAX_LEN);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [LEN_W-1:0]    r_idx, w_idx_nxt;
  logic [LEN_W-1:0]    r_len, w_len_nxt;
  logic [31:0]         r_salt, w_salt_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic [31:0]         r_data, w_data_nxt;
  logic                r_valid, w_valid_nxt;
  logic [31:0]         r_hash, w_hash_nxt;

  logic [LEN_W-1:0]    w_len_clamp;
  logic [LEN_W-1:0]    w_idx_inc;
  logic [31:0]         w_mix;
  logic [31:0]         w_prod;

  assign w_len_clamp = (len_i > c_MAX_LEN) ? c_MAX_LEN : len_i;
  assign w_idx_inc   = r_idx + 1'b1;

  // One multiplier serves both the first word (from the live seed) and every
  // following word (from the word currently on the bus), so no valid bubble.
  assign w_mix  = (r_state == ST_IDLE) ? (seed_i ^ salt_i)
                                       : (r_data ^ (r_salt + 32'(w_idx_inc)));
  assign w_prod = w_mix * FNV_PRIME;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_len   <= '0;
      r_salt  <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_hash  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_len   <= w_len_nxt;
      r_salt  <= w_salt_nxt;
      r_addr  <= w_addr_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_hash  <= w_hash_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_len_nxt   = r_len;
    w_salt_nxt  = r_salt;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_valid_nxt = r_valid;
    w_hash_nxt  = r_hash;

    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          w_salt_nxt = salt_i;
          w_len_nxt  = w_len_clamp;
          w_idx_nxt  = '0;
          if (!cond_i || (w_len_clamp == '0)) begin
            w_hash_nxt  = seed_i;
            w_state_nxt = ST_DONE;
          end else begin
            w_valid_nxt = 1'b1;
            w_addr_nxt  = dest_i;
            w_data_nxt  = w_prod;
            w_state_nxt = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        if (r_valid && wr.wr_ready_i) begin
          if (w_idx_inc == r_len) begin
            w_hash_nxt  = r_data;
            w_valid_nxt = 1'b0;
            w_state_nxt = ST_DONE;
          end else begin
            w_idx_nxt  = w_idx_inc;
            w_addr_nxt = r_addr + 1'b1;
            w_data_nxt = w_prod;
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  assign wr.wr_valid_o = r_valid;
  assign wr.wr_addr_o  = r_addr;
  assign wr.wr_data_o  = r_data;
  assign busy_o        = (r_state != ST_IDLE);
  assign done_o        = (r_state == ST_DONE);
  assign hash_o        = r_hash;

endmodule
`default_nettype wire

// File: tb/tb_fnv1a_expand_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_fnv1a_expand_seq
// Brief    : Directed and randomized checks of fnv1a_expand_seq against a
//            chain-of-words reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fnv1a_expand_seq;

  localparam logic [31:0] c_PRIME = 32'h01000193;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic        cond_i = 1'b0;
  logic [31:0] seed_i = '0;
  logic [31:0] salt_i = '0;
  logic [7:0]  dest_i = '0;
  logic [5:0]  len_i = '0;
  logic        busy_o, done_o;
  logic [31:0] hash_o;

  int n_checks = 0;
  int n_fails  = 0;

  fnv1a_expand_seq_if #(.ADDR_W(8)) bus ();

  fnv1a_expand_seq #(
    .ADDR_W(8), .MAX_LEN(48), .LEN_W(6), .FNV_PRIME(c_PRIME)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .cond_i(cond_i),
    .seed_i(seed_i), .salt_i(salt_i), .dest_i(dest_i), .len_i(len_i),
    .wr(bus.master), .busy_o(busy_o), .done_o(done_o), .hash_o(hash_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ready_mode: 0 = always ready, 1 = stall_n low cycles on word stall_word, 2 = random
  task automatic run_op(input logic [31:0] seed, input logic [31:0] salt,
                        input logic [7:0] dest, input logic [5:0] len_in,
                        input logic cond, input int ready_mode,
                        input int stall_word, input int stall_n, input int extra_start);
    logic [31:0] exp_d[$];
    logic [31:0] h;
    int len, idx, stalls, st, done_cycle, cyc;
    len = cond ? ((len_in > 6'd48) ? 48 : int'(len_in)) : 0;
    h = seed;
    for (int i = 0; i < len; i++) begin
      h = (h ^ (salt + 32'(i))) * c_PRIME;
      exp_d.push_back(h);
    end
    idx = 0; stalls = 0; st = 0; done_cycle = -1;

    @(posedge clk); #1;
    seed_i = seed; salt_i = salt; dest_i = dest; len_i = len_in; cond_i = cond;
    start_i = 1'b1;
    bus.wr_ready_i = 1'b1;
    @(negedge clk);
    check("idle_before_start", 32'(busy_o), 32'd0);
    @(posedge clk); #1;
    // Scramble operands after start; the DUT must have latched its own copy.
    seed_i = $urandom; salt_i = $urandom; dest_i = 8'($urandom); len_i = 6'($urandom);
    cond_i = 1'($urandom);
    for (cyc = 1; cyc < 400; cyc++) begin
      start_i = (cyc == extra_start);
      case (ready_mode)
        1:       bus.wr_ready_i = !((idx == stall_word) && (st < stall_n));
        2:       bus.wr_ready_i = 1'($urandom);
        default: bus.wr_ready_i = 1'b1;
      endcase
      if (ready_mode == 1 && idx == stall_word && st < stall_n) st++;
      @(negedge clk);
      if (done_o) begin
        done_cycle = cyc;
        break;
      end
      check("busy_during_op", 32'(busy_o), 32'd1);
      if (idx < len) begin
        check("wr_valid", 32'(bus.wr_valid_o), 32'd1);
        check("wr_addr", 32'(bus.wr_addr_o), 32'(8'(dest + 8'(idx))));
        check("wr_data", bus.wr_data_o, exp_d[idx]);
        if (bus.wr_ready_i) idx++;
        else stalls++;
      end else begin
        check("no_extra_write", 32'(bus.wr_valid_o), 32'd0);
      end
      @(posedge clk); #1;
    end
    check("done_seen", 32'(done_cycle != -1), 32'd1);
    check("done_cycle", 32'(done_cycle), 32'(1 + len + stalls));
    check("write_count", 32'(idx), 32'(len));
    check("hash_at_done", hash_o, (len == 0) ? seed : exp_d[len-1]);
    check("valid_low_at_done", 32'(bus.wr_valid_o), 32'd0);
    start_i = (done_cycle == extra_start);
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("idle_after_done", {29'd0, busy_o, done_o, bus.wr_valid_o}, 32'd0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    bus.wr_ready_i = 1'b1;
    #12;
    check("reset_valid", 32'(bus.wr_valid_o), 32'd0);
    check("reset_busy_done", {30'd0, busy_o, done_o}, 32'd0);
    check("reset_hash", hash_o, 32'd0);
    check("reset_data", bus.wr_data_o, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single known-answer word
    run_op(32'h811c9dc5, 32'd0, 8'h10, 6'd1, 1'b1, 0, 0, 0, -1);
    check("kat_hash", hash_o, 32'h050c5d1f);

    run_op($urandom, $urandom, 8'h20, 6'd4, 1'b1, 0, 0, 0, -1);
    run_op($urandom, $urandom, 8'h40, 6'd4, 1'b1, 1, 2, 3, -1);
    run_op($urandom, 32'd0, 8'h00, 6'd5, 1'b0, 0, 0, 0, -1);
    run_op($urandom, $urandom, 8'h33, 6'd0, 1'b1, 0, 0, 0, -1);
    run_op($urandom, 32'hFFFF_FFFE, 8'hFE, 6'd4, 1'b1, 0, 0, 0, -1);
    run_op($urandom, $urandom, 8'hE0, 6'd63, 1'b1, 0, 0, 0, -1);
    // Start pulse mid-op and in the DONE cycle must both be ignored
    run_op($urandom, $urandom, 8'h50, 6'd6, 1'b1, 0, 0, 0, 3);
    run_op($urandom, $urandom, 8'h60, 6'd3, 1'b1, 0, 0, 0, 4);
    for (int r = 0; r < 6; r++)
      run_op($urandom, $urandom, 8'($urandom), 6'($urandom_range(1, 63)), 1'b1, 2, 0, 0, -1);

    // Asynchronous reset mid-operation
    @(posedge clk); #1;
    seed_i = $urandom; salt_i = $urandom; dest_i = 8'h70; len_i = 6'd10; cond_i = 1'b1;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(bus.wr_valid_o), 32'd0);
    check("async_rst_busy", 32'(busy_o), 32'd0);
    check("async_rst_addr_data", {bus.wr_addr_o, bus.wr_data_o[23:0]}, 32'd0);
    check("async_rst_hash", hash_o, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("post_rst_quiet", {30'd0, busy_o, bus.wr_valid_o}, 32'd0);
    end
    run_op($urandom, $urandom, 8'h80, 6'd3, 1'b1, 0, 0, 0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
